// File: rtl/div_hilo_ctrl_if.sv
// EX-stage request bus and divider handshake between the pipeline and div_hilo_ctrl.
// The master drives EX requests and the divider results; the slave is the controller.
interface div_hilo_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             ex_valid;
   logic             op_div;
   logic             op_mthi;
   logic             op_mtlo;
   logic             op_mfhi;
   logic             op_mflo;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             div_busy;
   logic [WIDTH-1:0] div_q;
   logic [WIDTH-1:0] div_r;
   logic             div_start;
   logic [WIDTH-1:0] div_dividend;
   logic [WIDTH-1:0] div_divisor;
   logic             stall;
   logic [WIDTH-1:0] mf_data;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_timeout;

   modport master (
      output ex_valid, op_div, op_mthi, op_mtlo, op_mfhi, op_mflo, rs_val, rt_val,
      output div_busy, div_q, div_r,
      input  div_start, div_dividend, div_divisor, stall, mf_data, hi, lo, div_timeout
   );

   modport slave (
      input  ex_valid, op_div, op_mthi, op_mtlo, op_mfhi, op_mflo, rs_val, rt_val,
      input  div_busy, div_q, div_r,
      output div_start, div_dividend, div_divisor, stall, mf_data, hi, lo, div_timeout
   );
endinterface

// File: rtl/div_hilo_ctrl.sv
// Sequences the iterative signed divider and owns HI/LO: issue, stall until busy drops,
// commit remainder/quotient, short-circuit divide-by-zero, abort a hung divider.
module div_hilo_ctrl #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 40
) (
   input  logic          clk_i,
   input  logic          reset_i,
   div_hilo_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CNT_W-1:0] wd_q, wd_d;
   logic             tmo_q, tmo_d;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         wd_q    <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         wd_q    <= wd_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      wd_d    = wd_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         IDLE: begin
            if (bus.ex_valid) begin
               if (bus.op_div) begin
                  // Divide-by-zero never reaches the divider: LO saturates, HI keeps the dividend.
                  if (bus.rt_val != '0) begin
                     dvd_d   = bus.rs_val;
                     dvs_d   = bus.rt_val;
                     state_d = ISSUE;
                  end else begin
                     lo_d = '1;
                     hi_d = bus.rs_val;
                  end
               end else if (bus.op_mthi) begin
                  hi_d = bus.rs_val;
               end else if (bus.op_mtlo) begin
                  lo_d = bus.rs_val;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
            wd_d    = '0;
         end
         WAIT: begin
            if (!bus.div_busy) begin
               hi_d    = bus.div_r;
               lo_d    = bus.div_q;
               state_d = IDLE;
            end else begin
               wd_d = wd_q + CNT_W'(1);
               if (wd_q == CNT_W'(TIMEOUT - 1)) begin
                  tmo_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode registered state only; mf_data shows pre-write register contents.
   always_comb begin
      bus.div_start = (state_q == ISSUE);
      bus.stall     = (state_q != IDLE);
      if (bus.op_mfhi)      bus.mf_data = hi_q;
      else if (bus.op_mflo) bus.mf_data = lo_q;
      else                  bus.mf_data = '0;
   end

   assign bus.hi           = hi_q;
   assign bus.lo           = lo_q;
   assign bus.div_dividend = dvd_q;
   assign bus.div_divisor  = dvs_q;
   assign bus.div_timeout  = tmo_q;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Randomized bench for div_hilo_ctrl with a negedge divider model and an arithmetic HI/LO reference.
module tb_div_hilo_ctrl;
   localparam int W  = 32;
   localparam int TO = 40;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   div_hilo_ctrl_if #(.WIDTH(W)) bus ();

   div_hilo_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Divider model: busy rises on the negedge that sees start and stays high for
   // lat_k posedge samples in WAIT; hang keeps it high indefinitely.
   int unsigned lat_k = 0;
   bit          hang  = 1'b0;
   int          cnt;

   always @(negedge clk or posedge reset) begin
      if (reset) begin
         bus.div_busy <= 1'b0;
         bus.div_q    <= '0;
         bus.div_r    <= '0;
         cnt          <= 0;
      end else if (bus.div_start) begin
         cnt          <= lat_k + 1;
         bus.div_busy <= 1'b1;
         bus.div_q    <= $signed(bus.div_dividend) / $signed(bus.div_divisor);
         bus.div_r    <= $signed(bus.div_dividend) % $signed(bus.div_divisor);
      end else if (cnt > 0 && !hang) begin
         cnt <= cnt - 1;
         if (cnt == 1) bus.div_busy <= 1'b0;
      end
   end

   logic [W-1:0] exp_hi, exp_lo;
   logic         exp_tmo;

   // Signed truncating division from magnitudes.
   function automatic logic [W-1:0] ref_q(logic [W-1:0] a, logic [W-1:0] b);
      longint sa, sb, ma, mb, mq;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      mq = ma / mb;
      return ((sa < 0) != (sb < 0)) ? W'(-mq) : W'(mq);
   endfunction

   function automatic logic [W-1:0] ref_r(logic [W-1:0] a, logic [W-1:0] b);
      longint sa, sb, ma, mb, mr;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      mr = ma % mb;
      return (sa < 0) ? W'(-mr) : W'(mr);
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.ex_valid = 1'b0;
      bus.op_div   = 1'b0;
      bus.op_mthi  = 1'b0;
      bus.op_mtlo  = 1'b0;
      bus.op_mfhi  = 1'b0;
      bus.op_mflo  = 1'b0;
   endtask

   task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int unsigned k, input bit hang_en, input bit mtlo_during);
      int stall_cnt = 0;
      int starts    = 0;
      int exp_stall;
      @(negedge clk);
      lat_k = k;
      hang  = hang_en;
      idle_inputs();
      bus.ex_valid = 1'b1;
      bus.op_div   = 1'b1;
      bus.rs_val   = a;
      bus.rt_val   = b;
      @(negedge clk);
      idle_inputs();
      if (b == '0) chk("divz_start", {31'b0, bus.div_start}, 32'd0);
      for (int c = 0; c < 200; c++) begin
         if (!bus.stall) break;
         stall_cnt++;
         if (bus.div_start) begin
            starts++;
            chk("dividend", bus.div_dividend, a);
            chk("divisor", bus.div_divisor, b);
         end
         if (mtlo_during && c == 2) begin
            bus.ex_valid = 1'b1;
            bus.op_mtlo  = 1'b1;
            bus.rs_val   = $urandom;
         end
         if (c == 6) idle_inputs();
         @(negedge clk);
      end
      idle_inputs();
      if (b == '0) begin
         exp_stall = 0;
         exp_hi    = a;
         exp_lo    = '1;
      end else if (hang_en || k >= TO) begin
         exp_stall = TO + 1;
         exp_tmo   = 1'b1;
      end else begin
         exp_stall = k + 2;
         exp_hi    = ref_r(a, b);
         exp_lo    = ref_q(a, b);
      end
      chk("stall_cycles", stall_cnt, exp_stall);
      chk("start_pulses", starts, (b == '0) ? 0 : 1);
      chk("div_hi", bus.hi, exp_hi);
      chk("div_lo", bus.lo, exp_lo);
      chk("timeout_flag", {31'b0, bus.div_timeout}, {31'b0, exp_tmo});
      hang = 1'b0;
   endtask

   task automatic do_mt(input bit to_hi, input logic [W-1:0] v);
      @(negedge clk);
      idle_inputs();
      bus.ex_valid = 1'b1;
      bus.rs_val   = v;
      if (to_hi) bus.op_mthi = 1'b1;
      else       bus.op_mtlo = 1'b1;
      @(negedge clk);
      idle_inputs();
      if (to_hi) exp_hi = v;
      else       exp_lo = v;
      chk(to_hi ? "mthi_hi" : "mtlo_lo", to_hi ? bus.hi : bus.lo, v);
   endtask

   task automatic do_mf(input bit from_hi);
      @(negedge clk);
      idle_inputs();
      bus.ex_valid = 1'b1;
      if (from_hi) bus.op_mfhi = 1'b1;
      else         bus.op_mflo = 1'b1;
      #1;
      chk(from_hi ? "mfhi_data" : "mflo_data", bus.mf_data, from_hi ? exp_hi : exp_lo);
      chk("mf_nostall", {31'b0, bus.stall}, 32'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("mf_idle_zero", bus.mf_data, '0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] a, b;
      int op;
      idle_inputs();
      bus.rs_val = '0;
      bus.rt_val = '0;
      reset = 1'b1;
      exp_hi  = '0;
      exp_lo  = '0;
      exp_tmo = 1'b0;
      #1;
      chk("rst_hi", bus.hi, '0);
      chk("rst_lo", bus.lo, '0);
      chk("rst_stall", {31'b0, bus.stall}, 32'd0);
      chk("rst_start", {31'b0, bus.div_start}, 32'd0);
      chk("rst_tmo", {31'b0, bus.div_timeout}, 32'd0);
      chk("rst_dividend", bus.div_dividend, '0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      do_div(32'd100, 32'd7, 31, 1'b0, 1'b0);
      chk("plan_lo14", bus.lo, 32'd14);
      chk("plan_hi2", bus.hi, 32'd2);
      do_mf(1'b0);
      do_div(32'hFFFF_FF9C, 32'd7, 31, 1'b0, 1'b0);
      chk("plan_neg_lo", bus.lo, 32'hFFFF_FFF2);
      chk("plan_neg_hi", bus.hi, 32'hFFFF_FFFE);
      do_div(32'h1234_5678, 32'd0, 31, 1'b0, 1'b0);
      do_mt(1'b1, 32'hDEAD_BEEF);
      do_mf(1'b1);
      do_div(32'd1000, 32'hFFFF_FFFD, 12, 1'b0, 1'b1);
      do_div(32'd55, 32'd5, 0, 1'b0, 1'b0);

      // Hung divider: watchdog aborts, HI/LO keep their values; busy stays stale-high afterwards.
      do_div(32'd77, 32'd3, 0, 1'b1, 1'b0);
      hang = 1'b1;
      do_mt(1'b0, 32'h0BAD_F00D);
      hang = 1'b0;

      // Asynchronous reset in the middle of WAIT.
      @(negedge clk);
      lat_k = 31;
      bus.ex_valid = 1'b1;
      bus.op_div   = 1'b1;
      bus.rs_val   = 32'd100;
      bus.rt_val   = 32'd7;
      @(negedge clk);
      idle_inputs();
      repeat (11) @(negedge clk);
      chk("pre_rst_stall", {31'b0, bus.stall}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("midrst_stall", {31'b0, bus.stall}, 32'd0);
      chk("midrst_start", {31'b0, bus.div_start}, 32'd0);
      chk("midrst_hi", bus.hi, '0);
      chk("midrst_lo", bus.lo, '0);
      chk("midrst_tmo", {31'b0, bus.div_timeout}, 32'd0);
      @(negedge clk);
      reset   = 1'b0;
      exp_hi  = '0;
      exp_lo  = '0;
      exp_tmo = 1'b0;
      do_div(32'd9, 32'd3, 31, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 4);
         case (op)
            0: begin
               a = $urandom;
               case ($urandom_range(0, 4))
                  0:       b = '0;
                  1:       b = $urandom_range(1, 20);
                  2:       b = -$urandom_range(1, 20);
                  default: b = $urandom;
               endcase
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
               do_div(a, b, $urandom_range(0, 39), 1'b0, ($urandom_range(0, 3) == 0));
            end
            1: do_mt(1'b1, $urandom);
            2: do_mt(1'b0, $urandom);
            3: do_mf(1'b1);
            default: do_mf(1'b0);
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/div_hilo_ctrl.md
Name: div_hilo_ctrl

Overview:
- Sequencing controller for the 32-bit iterative signed divider in the EX stage, plus owner of the HI/LO architectural registers.
- Accepts DIV/MTHI/MTLO/MFHI/MFLO requests from EX and issues a one-cycle start pulse to the divider.
- Stalls the pipeline until the divider drops busy, then commits remainder to HI and quotient to LO.
- Short-circuits divide-by-zero and guards against a hung divider with a watchdog.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- TIMEOUT, 40, max posedge cycles in WAIT before forced abort.

Ports:
- clk  in  1  pipeline clock; controller is posedge. The divider runs on negedge of the same clock.
- reset  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  EX holds a valid, non-flushed instruction.
- op_div  in  1  EX instruction is DIV (signed).
- op_mthi  in  1  EX instruction is MTHI.
- op_mtlo  in  1  EX instruction is MTLO.
- op_mfhi  in  1  EX instruction is MFHI.
- op_mflo  in  1  EX instruction is MFLO.
- rs_val  in  WIDTH  dividend, or MTHI/MTLO source.
- rt_val  in  WIDTH  divisor.
- div_busy  in  1  divider busy.
- div_q  in  WIDTH  divider quotient.
- div_r  in  WIDTH  divider remainder.
- div_start  out  1  start pulse to divider.
- div_dividend  out  WIDTH  latched dividend.
- div_divisor  out  WIDTH  latched divisor.
- stall  out  1  freeze IF/ID/EX.
- mf_data  out  WIDTH  MFHI/MFLO result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- div_timeout  out  1  sticky watchdog error flag.

Behaviour:
- Reset values: state IDLE; hi, lo, div_dividend, div_divisor = 0; div_start, stall, div_timeout = 0; watchdog counter = 0.
- States: IDLE, ISSUE, WAIT.
- Request precedence: at most one op_* is asserted per cycle. Requests are ignored unless ex_valid && state==IDLE.
- IDLE, ex_valid && op_div && rt_val!=0:
  - latch rs_val→div_dividend and rt_val→div_divisor;
  - next state ISSUE.
- IDLE, ex_valid && op_div && rt_val==0:
  - no divider issue;
  - at the same edge: lo←all ones, hi←rs_val;
  - stay IDLE; zero stall cycles.
- ISSUE:
  - div_start=1, registered, high for exactly this one cycle;
  - divider samples start on the mid-cycle negedge;
  - next state WAIT; watchdog←0.
- WAIT:
  - div_busy is sampled at posedge only;
  - if div_busy==0: hi←div_r, lo←div_q, next IDLE;
  - else watchdog+1; if watchdog==TIMEOUT-1: div_timeout←1, next IDLE, hi/lo unchanged.
- stall = (state!=IDLE), registered-state decode, no combinational path from inputs.
- Latency: DIV accepted at edge P0 → ISSUE P0–P1 → WAIT from P1 → busy low before P33 → hi/lo written at P33, IDLE after P33. stall is high for exactly 33 cycles.
- The issuing DIV itself advances; younger instructions are held by stall. MFHI/MFLO after a DIV therefore always see committed values.
- MTHI/MTLO in IDLE: hi or lo ← rs_val at that edge.
- mf_data combinational: op_mfhi ? hi : op_mflo ? lo : 0. It reflects register contents before any same-edge write.
- div_busy high while IDLE (stale) is ignored.
- div_busy already low in the first WAIT cycle is legal: commit immediately.
- Reset mid-operation: return to IDLE, clear hi/lo, drop stall and div_start immediately (async). The divider is reset by the same net.
- div_timeout clears only on reset.

Test Plan:
- DIV rs=100, rt=7 → div_start pulses 1 cycle, stall high 33 cycles, then hi=2, lo=14; MFLO next cycle mf_data=14.
- DIV rs=-100 (0xFFFFFF9C), rt=7 → lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2).
- DIV rs=0x12345678, rt=0 → no div_start, stall never high, lo=0xFFFFFFFF, hi=0x12345678 at the same edge.
- MTHI 0xDEADBEEF then MFHI → hi=0xDEADBEEF, mf_data=0xDEADBEEF. MTLO asserted during an in-flight DIV → ignored, lo ends as the quotient.
- Divider model holds div_busy high forever → after TIMEOUT (40) WAIT cycles: div_timeout=1, stall drops, hi/lo unchanged.
- Assert reset at cycle 10 of WAIT → stall=0, hi=lo=0, state IDLE. A new DIV 9/3 afterwards completes with lo=3, hi=0.
